// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic [0:0] {
    REQ_CORE = 1'b0,
    REQ_HOST = 1'b1
  } req_id_t;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;

  // Bits needed to hold the values 0..lim inclusive
  function automatic int unsigned ctr_width(input int unsigned lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_sat_ctr.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module dmem_arb_sat_ctr #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_limit_c
);

  assign at_limit_c = (cnt == W'(LIMIT));

  // Count register, holds at LIMIT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit_c) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core LSU and the Caravel host,
// with host-starvation aging and a host lock for atomic bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned LOCK_TO  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic              core_we,
  input  logic [2:0]        core_funct3,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_rsp_valid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rsp_valid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned WAIT_W = ctr_width(MAX_WAIT);
  localparam int unsigned LOCK_W = ctr_width(LOCK_TO);

  arb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic              wait_max_c, lock_to_c;
  logic              gnt_any_c;
  req_id_t           gnt_id_c;

  // Host starvation age: counts cycles the host is left waiting
  dmem_arb_sat_ctr #(.LIMIT(MAX_WAIT), .W(WAIT_W)) u_wait_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (host_req_ready),
    .inc        (host_req_valid && !host_req_ready),
    .cnt        (wait_cnt),
    .at_limit_c (wait_max_c)
  );

  // Lock idle timer: only runs while LOCKED and the host is silent
  dmem_arb_sat_ctr #(.LIMIT(LOCK_TO), .W(LOCK_W)) u_lock_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (host_req_ready || (state_q == ARB)),
    .inc        ((state_q == LOCKED) && !host_req_valid),
    .cnt        (lock_cnt),
    .at_limit_c (lock_to_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant decision and next state; nothing is granted while in reset
  always_comb begin
    state_d        = state_q;
    core_req_ready = 1'b0;
    host_req_ready = 1'b0;
    if (rst_n) begin
      case (state_q)
        ARB: begin
          if (host_req_valid && (wait_max_c || !core_req_valid)) begin
            host_req_ready = 1'b1;
            if (host_lock) state_d = LOCKED;
          end else if (core_req_valid) begin
            core_req_ready = 1'b1;
          end
        end
        LOCKED: begin
          if (lock_to_c) begin
            state_d = ARB;
          end else if (host_req_valid) begin
            host_req_ready = 1'b1;
            if (!host_lock) state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  assign gnt_any_c = core_req_ready || host_req_ready;
  assign gnt_id_c  = host_req_ready ? REQ_HOST : REQ_CORE;

  // Memory drive mux; idle bus parks at address 0, word size, no write
  always_comb begin
    mem_write  = 1'b0;
    mem_funct3 = F3_WORD;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (gnt_any_c) begin
      if (gnt_id_c == REQ_HOST) begin
        mem_write  = host_we;
        mem_funct3 = F3_WORD;
        mem_addr   = host_addr;
        mem_wdata  = host_wdata;
      end else begin
        mem_write  = core_we;
        mem_funct3 = core_funct3;
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
      end
    end
  end

  // Registered responses; read data captured in the accept cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_rsp_valid <= 1'b0;
      core_rdata     <= '0;
      host_rsp_valid <= 1'b0;
      host_rdata     <= '0;
    end else begin
      core_rsp_valid <= core_req_ready;
      host_rsp_valid <= host_req_ready;
      if (core_req_ready) core_rdata <= core_we ? '0 : mem_rdata;
      if (host_req_ready) host_rdata <= host_we ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded bench for dmem_arbiter with a behavioural 16-word memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req_valid, core_req_ready, core_we, core_rsp_valid;
  logic [2:0]  core_funct3;
  logic [3:0]  core_addr;
  logic [31:0] core_wdata, core_rdata;
  logic        host_req_valid, host_req_ready, host_we, host_lock, host_rsp_valid;
  logic [3:0]  host_addr;
  logic [31:0] host_wdata, host_rdata;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] phys_mem [16];
  logic [31:0] ref_mem  [16];
  logic [31:0] core_q [$];
  logic [31:0] host_q [$];
  logic [31:0] mon_exp;
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(4), .DATA_W(32), .MAX_WAIT(4), .LOCK_TO(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_we(core_we), .core_funct3(core_funct3), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rsp_valid(core_rsp_valid), .core_rdata(core_rdata),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rsp_valid(host_rsp_valid), .host_rdata(host_rdata),
    .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [2:0] f3);
    case (f3)
      F3_BYTE: return {old[31:8], wd[7:0]};
      F3_HALF: return {old[31:16], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  // Behavioural memory: combinational read, sized write at the clock edge
  assign mem_rdata = phys_mem[mem_addr];
  always @(posedge clk) if (mem_write) phys_mem[mem_addr] <= merge(phys_mem[mem_addr], mem_wdata, mem_funct3);

  // Response monitor: a response is due exactly one cycle after each accept
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      vectors++;
      if (core_q.size() > 0) begin
        mon_exp = core_q.pop_front();
        if (core_rsp_valid !== 1'b1 || core_rdata !== mon_exp) begin
          miscompares++;
          $display("FAIL core_rsp at %0t: valid=%b rdata=%h, want valid=1 rdata=%h", $time, core_rsp_valid, core_rdata, mon_exp);
        end
      end else if (core_rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL core_rsp_idle at %0t: valid=%b, want 0", $time, core_rsp_valid);
      end
      vectors++;
      if (host_q.size() > 0) begin
        mon_exp = host_q.pop_front();
        if (host_rsp_valid !== 1'b1 || host_rdata !== mon_exp) begin
          miscompares++;
          $display("FAIL host_rsp at %0t: valid=%b rdata=%h, want valid=1 rdata=%h", $time, host_rsp_valid, host_rdata, mon_exp);
        end
      end else if (host_rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL host_rsp_idle at %0t: valid=%b, want 0", $time, host_rsp_valid);
      end
    end
  end

  // Drive one cycle of requests, record accepts and push expected responses
  task automatic step(input logic cv, input logic cwe, input logic [2:0] cf3,
                      input logic [3:0] ca, input logic [31:0] cd,
                      input logic hv, input logic hwe, input logic hl,
                      input logic [3:0] ha, input logic [31:0] hd,
                      output logic cacc, output logic hacc);
    core_req_valid = cv; core_we = cwe; core_funct3 = cf3; core_addr = ca; core_wdata = cd;
    host_req_valid = hv; host_we = hwe; host_lock = hl; host_addr = ha; host_wdata = hd;
    @(negedge clk);
    cacc = core_req_valid & core_req_ready;
    hacc = host_req_valid & host_req_ready;
    if (cacc) begin
      core_q.push_back(cwe ? 32'h0 : ref_mem[ca]);
      if (cwe) ref_mem[ca] = merge(ref_mem[ca], cd, cf3);
    end
    if (hacc) begin
      host_q.push_back(hwe ? 32'h0 : ref_mem[ha]);
      if (hwe) ref_mem[ha] = hd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    core_req_valid = 1'b1; core_we = 1'b1; core_funct3 = F3_BYTE; core_addr = 4'd9; core_wdata = 32'hFFFF_FFFF;
    host_req_valid = 1'b1; host_we = 1'b1; host_lock = 1'b1; host_addr = 4'd7; host_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    vectors++;
    if (core_req_ready !== 1'b0 || host_req_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready: core=%b host=%b, want 0 0", core_req_ready, host_req_ready);
    end
    vectors++;
    if (mem_write !== 1'b0 || mem_addr !== 4'd0 || mem_wdata !== 32'h0 || mem_funct3 !== 3'b010) begin
      miscompares++;
      $display("FAIL reset_mem: we=%b addr=%h wd=%h f3=%b, want 0 0 0 010", mem_write, mem_addr, mem_wdata, mem_funct3);
    end
    vectors++;
    if (core_rsp_valid !== 1'b0 || host_rsp_valid !== 1'b0 || core_rdata !== 32'h0 || host_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rsp: cv=%b hv=%b crd=%h hrd=%h, want all 0", core_rsp_valid, host_rsp_valid, core_rdata, host_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; core_req_valid = 1'b0; host_req_valid = 1'b0; host_lock = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_core_only();
    logic ca, ha;
    step(1, 1, F3_WORD, 4'd3, 32'hDEAD_BEEF, 0, 0, 0, 4'd0, 32'h0, ca, ha);
    vectors++;
    if (ca !== 1'b1) begin miscompares++; $display("FAIL core_store_accept: got %b want 1", ca); end
    step(1, 0, F3_WORD, 4'd3, 32'h0, 0, 0, 0, 4'd0, 32'h0, ca, ha);
    vectors++;
    if (ca !== 1'b1) begin miscompares++; $display("FAIL core_load_accept: got %b want 1", ca); end
    vectors++;
    if (core_rsp_valid !== 1'b1 || core_rdata !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL core_load_data: valid=%b rdata=%h want 1 deadbeef", core_rsp_valid, core_rdata);
    end
    step(0, 0, F3_WORD, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0, ca, ha);
  endtask

  task automatic test_sized_store();
    logic ca, ha;
    step(1, 1, F3_BYTE, 4'd5, 32'h1234_5678, 0, 0, 0, 4'd0, 32'h0, ca, ha);
    step(0, 0, F3_WORD, 4'd0, 32'h0, 1, 0, 0, 4'd5, 32'h0, ca, ha);
    vectors++;
    if (ha !== 1'b1) begin miscompares++; $display("FAIL host_read_accept: got %b want 1", ha); end
    vectors++;
    if (host_rdata !== 32'h0000_0078) begin
      miscompares++; $display("FAIL byte_store: host_rdata=%h want 00000078", host_rdata);
    end
    step(1, 1, F3_WORD, 4'd7, 32'hFFFF_FFFF, 0, 0, 0, 4'd0, 32'h0, ca, ha);
    step(1, 1, F3_HALF, 4'd7, 32'hAAAA_5555, 0, 0, 0, 4'd0, 32'h0, ca, ha);
    step(1, 0, F3_WORD, 4'd7, 32'h0, 0, 0, 0, 4'd0, 32'h0, ca, ha);
    vectors++;
    if (core_rdata !== 32'hFFFF_5555) begin
      miscompares++; $display("FAIL half_store: core_rdata=%h want ffff5555", core_rdata);
    end
  endtask

  task automatic test_contention();
    logic ca, ha;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, F3_WORD, 4'(i), 32'h0, 1, 0, 0, 4'd5, 32'h0, ca, ha);
      vectors++;
      if (ca !== ((i % 5) != 4) || ha !== ((i % 5) == 4)) begin
        miscompares++;
        $display("FAIL contention cycle %0d: core_acc=%b host_acc=%b want %b %b", i, ca, ha, ((i % 5) != 4), ((i % 5) == 4));
      end
    end
  endtask

  task automatic test_lock();
    logic ca, ha;
    logic       hv_t [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       hl_t [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] ha_t [5] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3};
    for (int i = 0; i < 5; i++) begin
      step(i != 0, 0, F3_WORD, 4'd0, 32'h0, hv_t[i], 1, hl_t[i], ha_t[i], 32'hA000_0000 + 32'(i), ca, ha);
      vectors++;
      if (ca !== 1'b0 || ha !== hv_t[i]) begin
        miscompares++; $display("FAIL lock cycle %0d: core_acc=%b host_acc=%b want 0 %b", i, ca, ha, hv_t[i]);
      end
    end
    step(1, 0, F3_WORD, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0, ca, ha);
    vectors++;
    if (ca !== 1'b1) begin miscompares++; $display("FAIL lock_release: core_acc=%b want 1", ca); end
    for (int a = 1; a < 4; a++) step(1, 0, F3_WORD, 4'(a), 32'h0, 0, 0, 0, 4'd0, 32'h0, ca, ha);
  endtask

  task automatic test_lock_timeout();
    logic ca, ha;
    int   n;
    step(0, 0, F3_WORD, 4'd0, 32'h0, 1, 1, 1, 4'd4, 32'h4444_4444, ca, ha);
    vectors++;
    if (ha !== 1'b1) begin miscompares++; $display("FAIL lock_take: host_acc=%b want 1", ha); end
    n = 0;
    ca = 1'b0;
    while (!ca && n < 30) begin
      n++;
      step(1, 0, F3_WORD, 4'd4, 32'h0, 0, 0, 0, 4'd0, 32'h0, ca, ha);
    end
    vectors++;
    if (ca !== 1'b1 || n != 18) begin
      miscompares++; $display("FAIL lock_timeout: core accepted=%b at cycle %0d, want 1 at 18", ca, n);
    end
  endtask

  task automatic test_reset_mid_lock();
    logic ca, ha;
    step(0, 0, F3_WORD, 4'd0, 32'h0, 1, 1, 1, 4'd6, 32'h6666_6666, ca, ha);
    step(0, 0, F3_WORD, 4'd0, 32'h0, 1, 0, 1, 4'd6, 32'h0, ca, ha);
    vectors++;
    if (ha !== 1'b1) begin miscompares++; $display("FAIL locked_read_accept: host_acc=%b want 1", ha); end
    rst_n = 1'b0; core_req_valid = 1'b0; host_req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (host_req_ready !== 1'b0 || core_req_ready !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset_ready: core=%b host=%b want 0 0", core_req_ready, host_req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++;
    if (host_rsp_valid !== 1'b0 || core_rsp_valid !== 1'b0 || host_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL post_reset_rsp: host_v=%b core_v=%b host_rdata=%h want 0 0 0", host_rsp_valid, core_rsp_valid, host_rdata);
    end
    step(1, 0, F3_WORD, 4'd6, 32'h0, 1, 0, 0, 4'd6, 32'h0, ca, ha);
    vectors++;
    if (ca !== 1'b1 || ha !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_arb: core_acc=%b host_acc=%b want 1 0", ca, ha);
    end
    step(0, 0, F3_WORD, 4'd0, 32'h0, 1, 0, 0, 4'd6, 32'h0, ca, ha);
    vectors++;
    if (ha !== 1'b1) begin miscompares++; $display("FAIL post_reset_host: host_acc=%b want 1", ha); end
    step(0, 0, F3_WORD, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0, ca, ha);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      phys_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    test_reset();
    test_core_only();
    test_sized_store();
    test_contention();
    test_lock();
    test_lock_timeout();
    test_reset_mid_lock();
    repeat (2) @(posedge clk);
    #3;
    vectors++;
    if (core_q.size() != 0 || host_q.size() != 0) begin
      miscompares++; $display("FAIL drain: %0d core and %0d host responses outstanding", core_q.size(), host_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
